// File: rtl/calc_sequencer.sv
// Token-driven sequencer feeding a combinational ALU: collects operand/operator
// tokens, drives registered ALU inputs and accumulates results for chaining.
module calc_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             err
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_OP   = 2'd1;
    localparam logic [1:0] S_B    = 2'd2;
    localparam logic [1:0] S_EXEC = 2'd3;

    localparam logic [1:0] KIND_OPERAND  = 2'b00;
    localparam logic [1:0] KIND_OPERATOR = 2'b01;
    localparam logic [1:0] KIND_EQUALS   = 2'b10;
    localparam logic [1:0] KIND_CLEAR    = 2'b11;

    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] alu_a_nx, alu_b_nx, acc_nx;
    logic [2:0]       alu_op_nx;
    logic             out_valid_nx, err_nx;
    logic             take;
    logic [2:0]       opcode;
    logic             unary;

    assign in_ready = (state != S_EXEC);
    assign take     = in_valid && in_ready;
    assign opcode   = in_data[2:0];
    assign unary    = (opcode == OP_NOT) || (opcode == OP_NOP);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_A;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_NOP;
            acc       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            alu_a     <= alu_a_nx;
            alu_b     <= alu_b_nx;
            alu_op    <= alu_op_nx;
            acc       <= acc_nx;
            out_valid <= out_valid_nx;
            err       <= err_nx;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nx     = state;
        alu_a_nx     = alu_a;
        alu_b_nx     = alu_b;
        alu_op_nx    = alu_op;
        acc_nx       = acc;
        out_valid_nx = 1'b0;
        err_nx       = err;

        if (state == S_EXEC) begin
            acc_nx       = alu_result;
            alu_a_nx     = alu_result;
            out_valid_nx = 1'b1;
            state_nx     = S_OP;
        end else if (take && in_kind == KIND_CLEAR) begin
            state_nx  = S_A;
            alu_a_nx  = '0;
            alu_b_nx  = '0;
            alu_op_nx = OP_NOP;
            acc_nx    = '0;
            err_nx    = 1'b0;
        end else if (take) begin
            case (state)
                S_A: begin
                    case (in_kind)
                        KIND_OPERAND: begin
                            alu_a_nx = in_data;
                            acc_nx   = in_data;
                            state_nx = S_OP;
                        end
                        KIND_OPERATOR: begin
                            alu_a_nx  = acc;
                            alu_op_nx = opcode;
                            state_nx  = S_B;
                        end
                        KIND_EQUALS: out_valid_nx = 1'b1;
                        default: ;
                    endcase
                end
                S_OP: begin
                    case (in_kind)
                        KIND_OPERAND: begin
                            alu_a_nx = in_data;
                            acc_nx   = in_data;
                        end
                        KIND_OPERATOR: begin
                            alu_op_nx = opcode;
                            if (unary) begin
                                alu_b_nx = '0;
                                state_nx = S_EXEC;
                            end else begin
                                state_nx = S_B;
                            end
                        end
                        KIND_EQUALS: begin
                            out_valid_nx = 1'b1;
                            state_nx     = S_A;
                        end
                        default: ;
                    endcase
                end
                S_B: begin
                    case (in_kind)
                        KIND_OPERAND: begin
                            alu_b_nx = in_data;
                            state_nx = S_EXEC;
                        end
                        KIND_OPERATOR: begin
                            alu_op_nx = opcode;
                            if (unary) begin
                                alu_b_nx = '0;
                                state_nx = S_EXEC;
                            end
                        end
                        KIND_EQUALS: begin
                            // Dangling operator: flag it and drop back to the entered A
                            err_nx    = 1'b1;
                            alu_op_nx = OP_NOP;
                            state_nx  = S_OP;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios then random tokens,
// compared cycle by cycle against a token-level reference model.
module tb_calc_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_kind;
    logic [W-1:0] in_data;
    logic [W-1:0] alu_a, alu_b, alu_result, acc;
    logic [2:0]   alu_op;
    logic         out_valid, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_data(in_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .acc(acc),
        .out_valid(out_valid), .err(err)
    );

    // Behavioural 4-bit ALU standing in for the real one
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0: return W'(a + b);
            3'd1: return W'(a - b);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return (a < b) ? W'(1) : W'(0);
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase names follow the token grammar
    localparam int WANT_A = 0, WANT_OP = 1, WANT_B = 2, COMPUTING = 3;
    int           m_phase;
    logic [W-1:0] m_a, m_b, m_acc;
    logic [2:0]   m_op;
    logic         m_ov, m_err;

    function automatic bit m_ready();
        return m_phase != COMPUTING;
    endfunction

    task automatic m_clear();
        m_phase = WANT_A; m_a = '0; m_b = '0; m_op = 3'd7;
        m_acc = '0; m_ov = 1'b0; m_err = 1'b0;
    endtask

    task automatic m_step(input bit r, input bit v, input logic [1:0] k, input logic [W-1:0] d);
        bit is_unary;
        is_unary = (d[2:0] == 3'd5) || (d[2:0] == 3'd7);
        if (r) begin
            m_clear();
            return;
        end
        m_ov = 1'b0;
        if (m_phase == COMPUTING) begin
            m_acc = alu_fn(m_a, m_b, m_op);
            m_a = m_acc;
            m_ov = 1'b1;
            m_phase = WANT_OP;
            return;
        end
        if (!v) return;
        if (k == 2'b11) begin
            m_clear();
            return;
        end
        if (k == 2'b00) begin
            if (m_phase == WANT_B) begin
                m_b = d;
                m_phase = COMPUTING;
            end else begin
                m_a = d;
                m_acc = d;
                m_phase = WANT_OP;
            end
        end else if (k == 2'b01) begin
            if (m_phase == WANT_A) m_a = m_acc;
            m_op = d[2:0];
            if (m_phase != WANT_A && is_unary) begin
                m_b = '0;
                m_phase = COMPUTING;
            end else begin
                m_phase = WANT_B;
            end
        end else begin
            if (m_phase == WANT_B) begin
                m_err = 1'b1;
                m_op = 3'd7;
                m_phase = WANT_OP;
            end else begin
                m_ov = 1'b1;
                m_phase = WANT_A;
            end
        end
    endtask

    // One clock: drive, step model on the edge, compare shortly after
    task automatic cyc(input bit r, input bit v, input logic [1:0] k, input logic [W-1:0] d);
        bit acc_ok;
        rst = r; in_valid = v; in_kind = k; in_data = d;
        acc_ok = m_ready();
        @(posedge clk);
        m_step(r, v && acc_ok, k, d);
        #1;
        check("acc", int'(acc), int'(m_acc));
        check("out_valid", int'(out_valid), int'(m_ov));
        check("err", int'(err), int'(m_err));
        check("in_ready", int'(in_ready), int'(m_ready()));
        check("alu_a", int'(alu_a), int'(m_a));
        check("alu_b", int'(alu_b), int'(m_b));
        check("alu_op", int'(alu_op), int'(m_op));
    endtask

    task automatic send(input logic [1:0] k, input logic [W-1:0] d);
        bit done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            done = m_ready();
            cyc(1'b0, 1'b1, k, d);
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'b00, '0);
    endtask

    initial begin
        m_clear();
        rst = 1'b1; in_valid = 1'b0; in_kind = 2'b00; in_data = '0;
        cyc(1'b1, 1'b0, 2'b00, '0);
        check("reset_ready", int'(in_ready), 1);
        check("reset_op", int'(alu_op), 7);

        send(2'b00, 4'd3); send(2'b01, 4'd0); send(2'b00, 4'd5);
        check("exec_not_ready", int'(in_ready), 0);
        idle();
        check("plan_add", int'(acc), 8);
        check("plan_add_ov", int'(out_valid), 1);
        idle();
        check("ov_single", int'(out_valid), 0);
        send(2'b01, 4'd1); send(2'b00, 4'd2); idle();
        check("plan_sub", int'(acc), 6);
        send(2'b10, 4'd0);
        check("plan_eq_ov", int'(out_valid), 1);
        check("plan_eq_acc", int'(acc), 6);

        send(2'b00, 4'd3); send(2'b01, 4'd5); idle();
        check("plan_not", int'(acc), 12);
        send(2'b01, 4'd6); send(2'b00, 4'd13); idle();
        check("plan_lt", int'(acc), 1);

        send(2'b00, 4'd15); send(2'b01, 4'd0); send(2'b00, 4'd1); idle();
        check("plan_wrap_add", int'(acc), 0);
        send(2'b00, 4'd0); send(2'b01, 4'd1); send(2'b00, 4'd1); idle();
        check("plan_wrap_sub", int'(acc), 15);

        send(2'b00, 4'd4); send(2'b01, 4'd2); send(2'b10, 4'd0);
        check("plan_err", int'(err), 1);
        check("plan_err_acc", int'(acc), 4);
        send(2'b11, 4'd0);
        check("plan_clr_err", int'(err), 0);
        check("plan_clr_acc", int'(acc), 0);

        send(2'b00, 4'd1); send(2'b01, 4'd0); send(2'b00, 4'd2);
        send(2'b00, 4'd7);
        check("plan_hold", int'(acc), 7);
        send(2'b01, 4'd0); send(2'b00, 4'd1);
        cyc(1'b1, 1'b0, 2'b00, '0);
        check("plan_rst_exec_acc", int'(acc), 0);
        check("plan_rst_exec_ov", int'(out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [1:0] k;
            sel = int'($urandom_range(0, 99));
            k = (sel < 45) ? 2'b00 : (sel < 80) ? 2'b01 : (sel < 95) ? 2'b10 : 2'b11;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), k, W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
